// File: rtl/wave_gen_pkg.sv
// Shared constants for the multi-channel wave generator: mode encoding,
// register map and LFSR definition. No state; no backpressure.
package wave_gen_pkg;

  localparam int MODE_W = 4;
  localparam int MODE_INV_BIT = 3;

  localparam logic [2:0] MODE_OFF      = 3'd0;
  localparam logic [2:0] MODE_SQUARE   = 3'd1;
  localparam logic [2:0] MODE_SAW      = 3'd2;
  localparam logic [2:0] MODE_TRIANGLE = 3'd3;
  localparam logic [2:0] MODE_NOISE    = 3'd4;

  localparam logic [1:0] ADDR_FREQ = 2'd0;
  localparam logic [1:0] ADDR_MODE = 2'd1;
  localparam logic [1:0] ADDR_DUTY = 2'd2;
  localparam logic [1:0] ADDR_AMP  = 2'd3;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  function automatic logic mode_is_off(input logic [2:0] m);
    return (m == MODE_OFF) || (m > MODE_NOISE);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/wave_gen_channel.sv
// One DDS channel: accumulator, pending/active shape registers, LFSR, shaper, scaler.
// Sample is registered one cycle after acc; no backpressure, ena_i freezes state.
module wave_gen_channel
  import wave_gen_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic             freq_we_i,
  input  logic             mode_we_i,
  input  logic             duty_we_i,
  input  logic             amp_we_i,
  input  logic [ACC_W-1:0] wdata_i,
  output logic [OUT_W-1:0] wave_o,
  output logic             wrap_o
);

  logic [ACC_W-1:0]  acc_q, acc_d, freq_q, freq_d;
  logic [MODE_W-1:0] mode_q, mode_d, mode_p_q, mode_p_d;
  logic [OUT_W-1:0]  duty_q, duty_d, duty_p_q, duty_p_d;
  logic [OUT_W-1:0]  amp_q, amp_d, amp_p_q, amp_p_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              wrap_q, wrap_d;

  logic [ACC_W:0]     sum;
  logic               off, carry;
  logic [OUT_W-1:0]   p, tri_up, shape, raw, scaled;
  logic [OUT_W:0]     amp_inc;
  logic [2*OUT_W:0]   prod;
  logic               unused_prod;

  assign sum    = {1'b0, acc_q} + {1'b0, freq_q};
  assign off    = mode_is_off(mode_q[2:0]);
  assign carry  = ena_i && !off && sum[ACC_W];
  assign p      = acc_q[ACC_W-1 -: OUT_W];
  assign tri_up = {p[OUT_W-2:0], 1'b0};

  always_comb begin
    shape = '0;
    case (mode_q[2:0])
      MODE_SQUARE:   shape = (p < duty_q) ? {OUT_W{1'b1}} : '0;
      MODE_SAW:      shape = p;
      MODE_TRIANGLE: shape = p[OUT_W-1] ? ~tri_up : tri_up;
      MODE_NOISE:    shape = lfsr_q[OUT_W-1:0];
      default:       shape = '0;
    endcase
    raw = mode_q[MODE_INV_BIT] ? ~shape : shape;
  end

  // AMP+1 multiplier makes all-ones AMP an exact pass-through
  assign amp_inc     = {1'b0, amp_q} + (OUT_W+1)'(1);
  assign prod        = {{(OUT_W+1){1'b0}}, raw} * {{OUT_W{1'b0}}, amp_inc};
  assign scaled      = prod[2*OUT_W-1:OUT_W];
  assign unused_prod = ^{prod[2*OUT_W], prod[OUT_W-1:0]};

  always_comb begin
    acc_d    = acc_q;
    freq_d   = freq_q;
    mode_d   = mode_q;
    duty_d   = duty_q;
    amp_d    = amp_q;
    mode_p_d = mode_p_q;
    duty_p_d = duty_p_q;
    amp_p_d  = amp_p_q;
    lfsr_d   = lfsr_q;
    out_d    = out_q;
    wrap_d   = 1'b0;

    if (freq_we_i) freq_d   = wdata_i;
    if (mode_we_i) mode_p_d = wdata_i[MODE_W-1:0];
    if (duty_we_i) duty_p_d = wdata_i[OUT_W-1:0];
    if (amp_we_i)  amp_p_d  = wdata_i[OUT_W-1:0];

    // Commit uses the pending value from before this cycle's write
    if (off || carry) begin
      mode_d = mode_p_q;
      duty_d = duty_p_q;
      amp_d  = amp_p_q;
    end

    if (ena_i) begin
      acc_d  = off ? '0 : sum[ACC_W-1:0];
      out_d  = off ? '0 : scaled;
      wrap_d = carry;
      if (carry) lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      freq_q   <= '0;
      mode_q   <= {1'b0, MODE_OFF};
      duty_q   <= OUT_W'(1) << (OUT_W-1);
      amp_q    <= '1;
      mode_p_q <= {1'b0, MODE_OFF};
      duty_p_q <= OUT_W'(1) << (OUT_W-1);
      amp_p_q  <= '1;
      lfsr_q   <= SEED;
      out_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      freq_q   <= freq_d;
      mode_q   <= mode_d;
      duty_q   <= duty_d;
      amp_q    <= amp_d;
      mode_p_q <= mode_p_d;
      duty_p_q <= duty_p_d;
      amp_p_q  <= amp_p_d;
      lfsr_q   <= lfsr_d;
      out_q    <= out_d;
      wrap_q   <= wrap_d;
    end
  end

  assign wave_o = out_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/wave_gen_multi.sv
// NUM_CH independent DDS wave channels behind one shared register-write port.
// Samples registered one cycle after acc; no backpressure, one write per cycle.
module wave_gen_multi
  import wave_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [1:0]              cfg_addr,
  input  logic [ACC_W-1:0]        cfg_wdata,
  output logic [NUM_CH*OUT_W-1:0] wave_out,
  output logic [NUM_CH-1:0]       wrap
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    logic [OUT_W-1:0] ch_wave;
    logic ch_wrap;

    // Out-of-range channel indices never match any instance
    assign sel = cfg_we && (cfg_ch == CH_W'(i));

    wave_gen_channel #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SEED  (LFSR_SEED + LFSR_W'(i))
    ) u_ch (
      .clk_i     (clk),
      .rst_i     (rst),
      .ena_i     (ena),
      .freq_we_i (sel && (cfg_addr == ADDR_FREQ)),
      .mode_we_i (sel && (cfg_addr == ADDR_MODE)),
      .duty_we_i (sel && (cfg_addr == ADDR_DUTY)),
      .amp_we_i  (sel && (cfg_addr == ADDR_AMP)),
      .wdata_i   (cfg_wdata),
      .wave_o    (ch_wave),
      .wrap_o    (ch_wrap)
    );

    assign wave_out[i*OUT_W +: OUT_W] = ch_wave;
    assign wrap[i] = ch_wrap;
  end

endmodule

// File: tb/tb_wave_gen_multi.sv
// Bench for wave_gen_multi (3 channels): directed scenarios plus random config
// traffic, every cycle compared against an arithmetic reference model.
module tb_wave_gen_multi;
  localparam int NCH = 3;
  localparam int AW  = 16;
  localparam int OW  = 8;

  logic              clk = 1'b0;
  logic              rst, ena, cfg_we;
  logic [1:0]        cfg_ch, cfg_addr;
  logic [AW-1:0]     cfg_wdata;
  logic [NCH*OW-1:0] wave_out;
  logic [NCH-1:0]    wrap;

  wave_gen_multi #(.NUM_CH(NCH), .ACC_W(AW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .wave_out(wave_out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state, one entry per channel
  int m_acc[NCH], m_freq[NCH], m_lfsr[NCH], m_out[NCH];
  int m_mode[NCH], m_duty[NCH], m_amp[NCH];
  int p_mode[NCH], p_duty[NCH], p_amp[NCH];
  bit m_wrap[NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_off(input int m);
    int s;
    s = m & 7;
    return (s == 0) || (s > 4);
  endfunction

  function automatic int lfsr_step(input int s);
    int b;
    b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
    return (s >> 1) | (b << 15);
  endfunction

  function automatic int sample(input int c);
    int p, r;
    p = m_acc[c] >> (AW - OW);
    case (m_mode[c] & 7)
      1: r = (p < m_duty[c]) ? 255 : 0;
      2: r = p;
      3: r = (p < 128) ? 2 * p : 511 - 2 * p;
      4: r = m_lfsr[c] & 255;
      default: r = 0;
    endcase
    if ((m_mode[c] & 8) != 0) r = 255 - r;
    return (r * (m_amp[c] + 1)) / 256;
  endfunction

  task automatic model_clock();
    for (int c = 0; c < NCH; c++) begin
      bit off, carry;
      int sum;
      if (rst) begin
        m_acc[c] = 0; m_freq[c] = 0; m_out[c] = 0; m_wrap[c] = 0;
        m_mode[c] = 0; m_duty[c] = 128; m_amp[c] = 255;
        p_mode[c] = 0; p_duty[c] = 128; p_amp[c] = 255;
        m_lfsr[c] = 'hACE1 + c;
      end else begin
        off   = is_off(m_mode[c]);
        sum   = m_acc[c] + m_freq[c];
        carry = ena && !off && (sum >= 65536);
        if (ena) begin
          m_out[c]  = off ? 0 : sample(c);
          m_acc[c]  = off ? 0 : sum % 65536;
          m_wrap[c] = carry;
          if (carry) m_lfsr[c] = lfsr_step(m_lfsr[c]);
        end else begin
          m_wrap[c] = 0;
        end
        if (off || carry) begin
          m_mode[c] = p_mode[c]; m_duty[c] = p_duty[c]; m_amp[c] = p_amp[c];
        end
        if (cfg_we && int'(cfg_ch) == c) begin
          case (int'(cfg_addr))
            0: m_freq[c] = int'(cfg_wdata);
            1: p_mode[c] = int'(cfg_wdata) & 15;
            2: p_duty[c] = int'(cfg_wdata) & 255;
            default: p_amp[c] = int'(cfg_wdata) & 255;
          endcase
        end
      end
    end
  endtask

  task automatic step();
    logic [NCH*OW-1:0] ew;
    logic [NCH-1:0]    ewr;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      ew[c*OW +: OW] = OW'(m_out[c]);
      ewr[c] = m_wrap[c];
    end
    chk("wave_model", 32'(wave_out), 32'(ew));
    chk("wrap_model", 32'(wrap), 32'(ewr));
  endtask

  function automatic int ch_out(input int c);
    return int'(wave_out[c*OW +: OW]);
  endfunction

  task automatic wr(input int ch, input int addr, input int data);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_addr = 2'(addr); cfg_wdata = 16'(data);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_wrap(input int c, input int budget);
    int k;
    k = 0;
    while (!wrap[c] && k < budget) begin
      step();
      k++;
    end
    chk("wrap_seen", 32'(wrap[c]), 32'd1);
  endtask

  initial begin
    int n, ones, nz, mx, mn, a;
    logic [NCH*OW-1:0] snap;
    rst = 1'b1; ena = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
    run(2);
    rst = 1'b0;
    chk("rst_wave", 32'(wave_out), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    run(100);
    chk("idle_wave", 32'(wave_out), 32'd0);

    // saw on ch0
    wr(0, 0, 'h0100);
    wr(0, 1, 2);
    run(10);
    a = ch_out(0);
    step();
    chk("saw_inc", 32'(ch_out(0)), 32'((a + 1) & 255));
    wait_wrap(0, 300);
    n = 1;
    step();
    while (!wrap[0] && n < 300) begin step(); n++; end
    chk("saw_period", 32'(n), 32'd256);
    chk("ch1_idle", 32'(ch_out(1)), 32'd0);

    // square with 1/4 duty, then duty 0
    wr(0, 0, 'h1000);
    wr(0, 1, 1);
    wr(0, 2, 'h40);
    run(40);
    ones = 0;
    repeat (32) begin step(); if (ch_out(0) == 255) ones++; end
    chk("sq_duty40", 32'(ones), 32'd8);
    wr(0, 2, 0);
    run(40);
    nz = 0;
    repeat (32) begin step(); if (ch_out(0) != 0) nz++; end
    chk("sq_duty0", 32'(nz), 32'd0);

    // half-amplitude triangle on ch1, then inverted
    wr(1, 0, 'h0800);
    wr(1, 1, 3);
    wr(1, 3, 'h7F);
    run(70);
    mx = 0; mn = 255;
    repeat (64) begin
      step();
      if (ch_out(1) > mx) mx = ch_out(1);
      if (ch_out(1) < mn) mn = ch_out(1);
    end
    chk("tri_max", 32'(mx), 32'h7F);
    chk("tri_min", 32'(mn), 32'h00);
    wr(1, 1, 'hB);
    run(70);
    wait_wrap(1, 64);
    step();
    chk("tri_inv_peak", 32'(ch_out(1)), 32'h7F);

    // deferred commits on ch0, then freeze
    wr(0, 2, 'h80);
    run(40);
    wait_wrap(0, 32);
    run(5);
    wr(0, 1, 2);
    n = 0;
    while (!wrap[0] && n < 32) begin
      chk("mid_hold_square", 32'(ch_out(0) == 0 || ch_out(0) == 255), 32'd1);
      step();
      n++;
    end
    run(20);
    wait_wrap(0, 32);
    wr(0, 1, 1);
    run(40);
    snap = wave_out;
    ena = 1'b0;
    repeat (10) begin
      step();
      chk("frz_wave", 32'(wave_out), 32'(snap));
      chk("frz_wrap", 32'(wrap), 32'd0);
    end
    ena = 1'b1;
    run(50);

    // out-of-range channel, then noise on ch2
    wr(3, 0, 'h1234);
    wr(3, 1, 2);
    run(5);
    wr(2, 0, 'h8000);
    wr(2, 1, 4);
    step();
    step();
    chk("noise_first", 32'(ch_out(2)), 32'hE3);
    n = 0;
    repeat (20) begin step(); if (wrap[2]) n++; end
    chk("noise_wraps", 32'(n), 32'd10);

    // random traffic
    repeat (4000) begin
      rst    = ($urandom_range(0, 499) == 0);
      ena    = ($urandom_range(0, 9) != 0);
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_ch   = 2'($urandom_range(0, 3));
      cfg_addr = 2'($urandom_range(0, 3));
      if (cfg_addr == 2'd0 && $urandom_range(0, 1) == 0)
        cfg_wdata = 16'($urandom_range(0, 64) << 8);
      else
        cfg_wdata = 16'($urandom);
      step();
    end
    rst = 1'b0; cfg_we = 1'b0; ena = 1'b1;
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
